// File: rtl/hd_pkg.sv
// Shared types and defaults for the HD side-port responder.
// The entry struct is sized by HD_AW/HD_DW; the top parameters AW/DW must not exceed them.
package hd_pkg;

    localparam int HD_AW    = 32;
    localparam int HD_DW    = 32;
    localparam int HD_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_REQ  = 2'd1,
        RD_REQ  = 2'd2,
        RD_DONE = 2'd3
    } hdState_t;

    typedef struct packed {
        logic [HD_AW-1:0] addr;
        logic [HD_DW-1:0] data;
    } hdEntry_t;

endpackage

// File: rtl/hd_write_fifo.sv
// Posted-store buffer: DEPTH-entry circular queue of {addr, data}.
// Besides push/pop it looks at the newest entry so a store to the same address
// can be folded into it (only when combineEn is set by the parent).
module hd_write_fifo
    import hd_pkg::*;
#(
    parameter int DEPTH = HD_DEPTH
) (
    input  logic     Clock,
    input  logic     Reset,
    input  logic     wrEn,
    input  logic     combineEn,
    input  logic     headLocked,
    input  hdEntry_t wrEntry,
    input  logic     pop,
    output hdEntry_t headEntry,
    output logic     full,
    output logic     empty,
    output logic     combined
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    hdEntry_t      entries [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;
    logic          tailHit;
    logic          doPush;
    logic          doPop;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign tailPtr   = wrPtr - PW'(1);
    assign headEntry = entries[rdPtr];

    // The newest entry may absorb a store unless it is also the head that is
    // already on the bus (a single entry whose transaction is in flight).
    assign tailHit  = ~empty & (entries[tailPtr].addr == wrEntry.addr)
                    & ~((count == CW'(1)) & headLocked);
    assign combined = wrEn & combineEn & tailHit;
    assign doPush   = wrEn & ~combined & ~full;
    assign doPop    = pop & ~empty;

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge Clock) begin
        if (doPush) begin
            entries[wrPtr] <= wrEntry;
        end else if (combined) begin
            entries[tailPtr].data <= wrEntry.data;
        end
    end

endmodule

// File: rtl/hd_bus_responder.sv
// HD side-port responder: posts processor stores into a write buffer and turns
// buffered stores and loads into req/ack transactions toward the HD model.
// Optional feature: define HD_WRITE_COMBINE_EN to fold a store into the newest
// not-yet-issued buffered store with the same address.
//
// HD handshake: HdReq rises with HdWe/HdAddr/HdWData stable and they stay
// stable until HdAck is sampled high on a rising edge while HdReq is high; the
// transaction completes on that edge and HdReq is low for at least one cycle
// before the next request. HdAck outside a request is ignored.
module hd_bus_responder
    import hd_pkg::*;
#(
    parameter int DEPTH = HD_DEPTH,
    parameter int AW    = HD_AW,
    parameter int DW    = HD_DW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          WriteHD,
    input  logic          ReadHD,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWData,
    output logic          Stall,
    output logic          ReadValid,
    output logic [DW-1:0] ReadData,
    output logic          HdReq,
    output logic          HdWe,
    output logic [AW-1:0] HdAddr,
    output logic [DW-1:0] HdWData,
    input  logic          HdAck,
    input  logic [DW-1:0] HdRData,
    output hdState_t      DbgState
);

`ifdef HD_WRITE_COMBINE_EN
    localparam logic COMBINE_EN = 1'b1;
`else
    localparam logic COMBINE_EN = 1'b0;
`endif

    hdState_t      state;
    hdState_t      stateNext;
    logic [AW-1:0] rdAddr;
    logic          loadRdAddr;
    logic          captureRd;
    logic          pop;
    hdEntry_t      wrEntry;
    hdEntry_t      headEntry;
    logic          bufFull;
    logic          bufEmpty;
    logic          combined;

    // Store from the processor, widened into a buffer entry.
    always_comb begin
        wrEntry               = '0;
        wrEntry.addr[AW-1:0]  = CpuAddr;
        wrEntry.data[DW-1:0]  = CpuWData;
    end

    hd_write_fifo #(
        .DEPTH(DEPTH)
    ) u_write_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .wrEn      (WriteHD),
        .combineEn (COMBINE_EN),
        .headLocked(state == WR_REQ),
        .wrEntry   (wrEntry),
        .pop       (pop),
        .headEntry (headEntry),
        .full      (bufFull),
        .empty     (bufEmpty),
        .combined  (combined)
    );

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: writes always drain before a read is started, and a read that
    // arrives together with a store waits for that store.
    always_comb begin
        stateNext  = state;
        pop        = 1'b0;
        loadRdAddr = 1'b0;
        captureRd  = 1'b0;
        case (state)
            IDLE: begin
                if (!bufEmpty) begin
                    stateNext = WR_REQ;
                end else if (ReadHD && !WriteHD) begin
                    stateNext  = RD_REQ;
                    loadRdAddr = 1'b1;
                end
            end
            WR_REQ: begin
                if (HdAck) begin
                    pop       = 1'b1;
                    stateNext = IDLE;
                end
            end
            RD_REQ: begin
                if (HdAck) begin
                    captureRd = 1'b1;
                    stateNext = RD_DONE;
                end
            end
            RD_DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Load address and returned data are held in registers across the transaction.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdAddr   <= '0;
            ReadData <= '0;
        end else begin
            if (loadRdAddr) rdAddr   <= CpuAddr;
            if (captureRd)  ReadData <= HdRData;
        end
    end

    // Bus outputs follow the state directly so reset drops them at once.
    always_comb begin
        HdReq   = (state == WR_REQ) || (state == RD_REQ);
        HdWe    = (state == WR_REQ);
        HdAddr  = '0;
        HdWData = '0;
        if (state == WR_REQ) begin
            HdAddr  = headEntry.addr[AW-1:0];
            HdWData = headEntry.data[DW-1:0];
        end else if (state == RD_REQ) begin
            HdAddr = rdAddr;
        end
    end

    // A store that folds into the buffer never stalls, even with the buffer full.
    assign Stall     = (bufFull & ~combined) | (ReadHD & (state != RD_DONE));
    assign ReadValid = (state == RD_DONE);
    assign DbgState  = state;

endmodule

// File: tb/tb_hd_bus_responder.sv
// Bench for hd_bus_responder: directed scenarios plus a randomized run, with a
// transaction-level model of the processor-visible memory and the posted stores.
module tb_hd_bus_responder;
    import hd_pkg::*;

    localparam int DEPTH = 4;
`ifdef HD_WRITE_COMBINE_EN
    localparam int COMBINE_WRITES = 2;
`else
    localparam int COMBINE_WRITES = 3;
`endif

    logic        Clock;
    logic        Reset;
    logic        WriteHD;
    logic        ReadHD;
    logic [31:0] CpuAddr;
    logic [31:0] CpuWData;
    logic        Stall;
    logic        ReadValid;
    logic [31:0] ReadData;
    logic        HdReq;
    logic        HdWe;
    logic [31:0] HdAddr;
    logic [31:0] HdWData;
    logic        HdAck;
    logic [31:0] HdRData;
    hdState_t    dbgState;

    hd_bus_responder #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .WriteHD  (WriteHD),
        .ReadHD   (ReadHD),
        .CpuAddr  (CpuAddr),
        .CpuWData (CpuWData),
        .Stall    (Stall),
        .ReadValid(ReadValid),
        .ReadData (ReadData),
        .HdReq    (HdReq),
        .HdWe     (HdWe),
        .HdAddr   (HdAddr),
        .HdWData  (HdWData),
        .HdAck    (HdAck),
        .HdRData  (HdRData),
        .DbgState (dbgState)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / model state ----------------
    int testsRun    = 0;
    int testsFailed = 0;

    logic [63:0] exp_q[$];                 // posted stores not yet written to HD, oldest first
    logic [31:0] refMem [logic [31:0]];    // memory as the processor should see it
    logic [31:0] hdMem  [logic [31:0]];    // what the HD storage actually holds
    bit          frontIssued = 0;          // oldest posted store is on the bus
    logic [31:0] expRdAddr   = '0;

    bit hdStuck    = 0;
    bit hdManual   = 0;
    int fixedDelay = -1;
    int hdWrites   = 0;
    int lastHeld   = 0;
    int stallCount = 0;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] initVal(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    function automatic logic [31:0] hdRead(input logic [31:0] a);
        return hdMem.exists(a) ? hdMem[a] : initVal(a);
    endfunction

    // Processor-side store semantics: accepted if room, or folded into the
    // newest not-yet-issued store to the same address when combining is built in.
    task automatic modelStore(input logic [31:0] a, input logic [31:0] d, output bit ok);
        bit comb;
        comb = 0;
`ifdef HD_WRITE_COMBINE_EN
        if (exp_q.size() > 0 && !(exp_q.size() == 1 && frontIssued)
            && exp_q[exp_q.size()-1][63:32] == a)
            comb = 1;
`endif
        ok = comb || (exp_q.size() < DEPTH);
        if (comb) exp_q[exp_q.size()-1][31:0] = d;
        else if (ok) exp_q.push_back({a, d});
        if (ok) refMem[a] = d;
    endtask

    always @(negedge Clock) begin
        #1;
        if (Stall) stallCount++;
    end

    // ---------------- HD storage model ----------------
    bit          busy = 0;
    int          waitLeft = 0;
    int          held = 0;
    bit          txnWe = 0;
    logic [31:0] txnAddr = '0;
    logic [31:0] txnData = '0;

    initial begin : hd_model
        HdAck   = 1'b0;
        HdRData = '0;
        forever begin
            @(negedge Clock);
            if (hdManual) begin
                busy = 0;
            end else if (HdAck) begin
                // the responder saw the ack with its request high on the last edge
                HdAck    = 1'b0;
                busy     = 0;
                lastHeld = held;
                if (txnWe) begin
                    if (exp_q.size() > 0) checkValue("wr_done", {txnAddr, txnData}, exp_q.pop_front());
                    else checkValue("wr_extra", 1, 0);
                    hdMem[txnAddr] = txnData;
                    hdWrites++;
                    frontIssued = 0;
                end
                checkValue("req_gap", HdReq, 0);
            end else if (HdReq) begin
                if (!busy) begin
                    busy     = 1;
                    held     = 0;
                    txnWe    = HdWe;
                    txnAddr  = HdAddr;
                    txnData  = HdWData;
                    waitLeft = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 4));
                    if (HdWe) begin
                        if (exp_q.size() > 0) checkValue("wr_issue", {HdAddr, HdWData}, exp_q[0]);
                        else checkValue("wr_unexpected", 1, 0);
                        frontIssued = 1;
                    end else begin
                        checkValue("rd_after_drain", exp_q.size(), 0);
                        checkValue("rd_addr", HdAddr, expRdAddr);
                    end
                end else begin
                    checkValue("req_stable", {HdWe, HdAddr, HdWData}, {txnWe, txnAddr, txnData});
                end
                held++;
                if (!hdStuck) begin
                    if (waitLeft == 0) begin
                        HdAck = 1'b1;
                        if (!txnWe) HdRData = hdRead(txnAddr);
                    end else begin
                        waitLeft--;
                    end
                end
            end
        end
    end

    // ---------------- processor driver tasks ----------------
    task automatic idleCycle();
        @(negedge Clock);
        WriteHD = 1'b0;
        ReadHD  = 1'b0;
    endtask

    task automatic tryStore(input logic [31:0] a, input logic [31:0] d, output bit ok);
        @(negedge Clock);
        WriteHD  = 1'b1;
        ReadHD   = 1'b0;
        CpuAddr  = a;
        CpuWData = d;
        #1;
        modelStore(a, d, ok);
        checkValue("wr_stall", Stall, !ok);
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d);
        bit ok;
        int tries;
        tries = 0;
        do begin
            tryStore(a, d, ok);
            tries++;
        end while (!ok && tries < 100);
        if (!ok) checkValue("st_timeout", 0, 1);
    endtask

    task automatic doLoad(input logic [31:0] a, input int expLat,
                          input bit withStore, input logic [31:0] d);
        logic [31:0] expData;
        bit          ok;
        bit          got;
        int          cyc;
        @(negedge Clock);
        ReadHD    = 1'b1;
        WriteHD   = withStore;
        CpuAddr   = a;
        CpuWData  = d;
        expRdAddr = a;
        #1;
        if (withStore) begin
            modelStore(a, d, ok);
            checkValue("sl_accept", ok, 1);
        end
        expData = refRead(a);
        cyc = 0;
        got = 0;
        while (!got && cyc < 80) begin
            if (ReadValid) begin
                got = 1;
                checkValue("ld_data", ReadData, expData);
                checkValue("ld_stall_done", Stall, 0);
                if (expLat >= 0) checkValue("ld_latency", cyc, expLat);
            end else begin
                checkValue("ld_stall", Stall, 1);
                @(negedge Clock);
                WriteHD = 1'b0;
                cyc++;
                #1;
            end
        end
        if (!got) checkValue("ld_timeout", 0, 1);
        @(negedge Clock);
        ReadHD = 1'b0;
        #1;
        checkValue("rv_pulse", ReadValid, 0);
        checkValue("rd_hold", ReadData, expData);
    endtask

    task automatic waitDrain();
        bit done;
        done = 0;
        @(negedge Clock);
        WriteHD = 1'b0;
        ReadHD  = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge Clock);
            #1;
            if (exp_q.size() == 0 && !HdReq) done = 1;
        end
        if (!done) checkValue("drain_timeout", 0, 1);
    endtask

    task automatic waitReq();
        bit seen;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge Clock);
            #1;
            if (HdReq) seen = 1;
        end
        if (!seen) checkValue("req_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit          ok;
        int          w0;
        int          s0;
        int          op;
        logic [31:0] a;

        Reset    = 1'b0;
        WriteHD  = 1'b0;
        ReadHD   = 1'b0;
        CpuAddr  = '0;
        CpuWData = '0;
        repeat (2) @(negedge Clock);
        #1;
        checkValue("rst_hdreq", HdReq, 0);
        checkValue("rst_hdwe", HdWe, 0);
        checkValue("rst_stall", Stall, 0);
        checkValue("rst_rvalid", ReadValid, 0);
        checkValue("rst_hdaddr", HdAddr, 0);
        checkValue("rst_hdwdata", HdWData, 0);
        checkValue("rst_rdata", ReadData, 0);
        checkValue("rst_state", dbgState, IDLE);
        @(negedge Clock);
        Reset = 1'b1;

        // single store, HD acks in the second request cycle
        fixedDelay = 1;
        w0 = hdWrites;
        s0 = stallCount;
        tryStore(32'h10, 32'hCAFE, ok);
        waitDrain();
        repeat (2) @(negedge Clock);
        #1;
        checkValue("st_held", lastHeld, 2);
        checkValue("st_writes", hdWrites - w0, 1);
        checkValue("st_no_stall", stallCount - s0, 0);
        checkValue("st_idle", HdReq, 0);

        // five back-to-back stores with the HD stalled
        hdStuck = 1;
        w0 = hdWrites;
        for (int i = 0; i < 5; i++) tryStore(32'h200 + 4 * i, i + 1, ok);
        idleCycle();
        hdStuck = 0;
        fixedDelay = -1;
        doStore(32'h210, 5);
        waitDrain();
        checkValue("five_writes", hdWrites - w0, 5);

        // store then immediate load of the same address
        tryStore(32'h20, 32'h55, ok);
        doLoad(32'h20, -1, 0, 0);

        // load latency with empty buffer, ack in cycle 3
        waitDrain();
        fixedDelay = 2;
        doLoad(32'h300, 4, 0, 0);
        fixedDelay = -1;

        // store and load in the same cycle: store lands first
        waitDrain();
        doLoad(32'h50, -1, 1, 32'h77);

        // reset while a write is on the bus with two stores buffered
        waitDrain();
        hdStuck = 1;
        tryStore(32'h100, 32'hA1, ok);
        tryStore(32'h104, 32'hA2, ok);
        idleCycle();
        waitReq();
        #2;
        Reset    = 1'b0;
        hdManual = 1;
        #1;
        checkValue("mid_rst_hdreq", HdReq, 0);
        checkValue("mid_rst_hdwe", HdWe, 0);
        checkValue("mid_rst_hdaddr", HdAddr, 0);
        checkValue("mid_rst_hdwdata", HdWData, 0);
        checkValue("mid_rst_stall", Stall, 0);
        checkValue("mid_rst_rvalid", ReadValid, 0);
        checkValue("mid_rst_rdata", ReadData, 0);
        exp_q.delete();
        frontIssued = 0;
        refMem = hdMem;
        @(negedge Clock);
        HdAck = 1'b1;
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            if (i == 1) HdAck = 1'b0;
            #1;
            checkValue("post_rst_idle", HdReq, 0);
        end
        HdAck    = 1'b0;
        hdStuck  = 0;
        hdManual = 0;
        doLoad(32'h100, -1, 0, 0);

        // two stores to one address while the HD is busy with another write
        waitDrain();
        w0 = hdWrites;
        hdStuck = 1;
        tryStore(32'h40, 32'h9, ok);
        idleCycle();
        waitReq();
        tryStore(32'h30, 32'h1, ok);
        tryStore(32'h30, 32'h2, ok);
        idleCycle();
        hdStuck = 0;
        waitDrain();
        checkValue("combine_writes", hdWrites - w0, COMBINE_WRITES);
        doLoad(32'h30, -1, 0, 0);

        // randomized traffic over a small address window
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            a  = 32'h400 + 4 * $urandom_range(0, 5);
            if (op < 5)      doStore(a, $urandom);
            else if (op < 7) doLoad(a, -1, 0, 0);
            else             idleCycle();
        end
        waitDrain();
        for (int i = 0; i < 6; i++) doLoad(32'h400 + 4 * i, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
